// File: rtl/openddr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : openddr_pkg
// Description : Shared DFI phase constants, types and byte-mask helper.
// Revision    : 1.0 - initial release
// ============================================================================
package openddr_pkg;

    localparam int DFI_NUM_PHASES      = 4;
    localparam int DFI_MAX_DATA_WIDTH  = 1024;
    localparam int DFI_MAX_MASK_WIDTH  = DFI_MAX_DATA_WIDTH / 8;

    typedef logic [DFI_NUM_PHASES-1:0] dfi_phase_vec_t;

    // Callers zero-extend narrower lanes into the maximum width and truncate back.
    function automatic logic [DFI_MAX_DATA_WIDTH-1:0] apply_byte_mask(
        input logic [DFI_MAX_DATA_WIDTH-1:0] data,
        input logic [DFI_MAX_MASK_WIDTH-1:0] mask,
        input logic [7:0]                    fill
    );
        logic [DFI_MAX_DATA_WIDTH-1:0] result;
        result = data;
        for (int b = 0; b < DFI_MAX_MASK_WIDTH; b++) begin
            if (mask[b]) begin
                result[b*8 +: 8] = fill;
            end
        end
        return result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/openddr_dfi_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : openddr_dfi_lat_pipe
// Description : Read-return delay line; requests enter at the stage selected
//               by i_lat and shift toward the registered output stage 0.
// Revision    : 1.0 - initial release
// ============================================================================
module openddr_dfi_lat_pipe
    import openddr_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int RD_LAT_MAX = 15,
    parameter int LAT_W      = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [LAT_W-1:0]                          i_lat,
    input  dfi_phase_vec_t                            i_valid,
    input  logic [DFI_NUM_PHASES-1:0][DATA_WIDTH-1:0] i_data,
    output dfi_phase_vec_t                            o_valid,
    output logic [DFI_NUM_PHASES-1:0][DATA_WIDTH-1:0] o_data,
    output logic                                      o_busy
);

    localparam int c_STAGES = RD_LAT_MAX + 1;

    dfi_phase_vec_t                            r_valid    [c_STAGES];
    logic [DFI_NUM_PHASES-1:0][DATA_WIDTH-1:0] r_data     [c_STAGES];
    dfi_phase_vec_t                            w_up_valid [c_STAGES];
    logic [DFI_NUM_PHASES-1:0][DATA_WIDTH-1:0] w_up_data  [c_STAGES];

    genvar k;
    generate
        for (k = 0; k < c_STAGES; k++) begin : g_stage
            if (k == c_STAGES - 1) begin : g_top
                assign w_up_valid[k] = '0;
                assign w_up_data[k]  = '0;
            end else begin : g_mid
                assign w_up_valid[k] = r_valid[k+1];
                assign w_up_data[k]  = r_data[k+1];
            end
        end
    endgenerate

    // Latency only changes while the line is empty, so the insert stage never collides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < c_STAGES; s++) begin
                r_valid[s] <= '0;
                r_data[s]  <= '0;
            end
        end else begin
            for (int s = 0; s < c_STAGES; s++) begin
                if (int'(i_lat) == s) begin
                    r_valid[s] <= i_valid;
                    r_data[s]  <= i_data;
                end else begin
                    r_valid[s] <= w_up_valid[s];
                    r_data[s]  <= w_up_data[s];
                end
            end
        end
    end

    always_comb begin
        o_busy = 1'b0;
        for (int s = 0; s < c_STAGES; s++) begin
            o_busy = o_busy | (|r_valid[s]);
        end
    end

    assign o_valid = r_valid[0];
    assign o_data  = r_data[0];

endmodule
`default_nettype wire

// File: rtl/openddr_dfi_phy_loopback.sv
`default_nettype none
// ============================================================================
// Module      : openddr_dfi_phy_loopback
// Description : Behavioural DFI PHY responder: write bursts fill a FIFO,
//               read requests return stored words after a programmable latency.
// Revision    : 1.0 - initial release
// ============================================================================
module openddr_dfi_phy_loopback
    import openddr_pkg::*;
#(
    parameter int         DATA_WIDTH = 64,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] MASK_FILL  = 8'h00,
    parameter int         RD_LAT_MAX = 15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [3:0]                  cfg_rd_lat,
    input  logic [DATA_WIDTH-1:0]       dfi_wrdata_0_p0,
    input  logic [DATA_WIDTH-1:0]       dfi_wrdata_0_p1,
    input  logic [DATA_WIDTH-1:0]       dfi_wrdata_1_p2,
    input  logic [DATA_WIDTH-1:0]       dfi_wrdata_1_p3,
    input  logic [DATA_WIDTH/8-1:0]     dfi_wrdata_mask_0_p0,
    input  logic [DATA_WIDTH/8-1:0]     dfi_wrdata_mask_0_p1,
    input  logic [DATA_WIDTH/8-1:0]     dfi_wrdata_mask_1_p2,
    input  logic [DATA_WIDTH/8-1:0]     dfi_wrdata_mask_1_p3,
    input  logic                        dfi_wrdata_en_0_p0,
    input  logic                        dfi_wrdata_en_0_p1,
    input  logic                        dfi_wrdata_en_1_p2,
    input  logic                        dfi_wrdata_en_1_p3,
    input  logic                        dfi_rddata_en_0_p0,
    input  logic                        dfi_rddata_en_0_p1,
    input  logic                        dfi_rddata_en_1_p2,
    input  logic                        dfi_rddata_en_1_p3,
    output logic [DATA_WIDTH-1:0]       dfi_rddata_0_p0,
    output logic [DATA_WIDTH-1:0]       dfi_rddata_0_p1,
    output logic [DATA_WIDTH-1:0]       dfi_rddata_1_p2,
    output logic [DATA_WIDTH-1:0]       dfi_rddata_1_p3,
    output logic                        dfi_rddata_valid_0_p0,
    output logic                        dfi_rddata_valid_0_p1,
    output logic                        dfi_rddata_valid_1_p2,
    output logic                        dfi_rddata_valid_1_p3,
    input  logic                        clr_status,
    output logic [$clog2(DEPTH):0]      fifo_count,
    output logic                        overflow,
    output logic                        underflow
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_MW    = DATA_WIDTH / 8;
    localparam int c_LAT_W = (RD_LAT_MAX > 0) ? $clog2(RD_LAT_MAX + 1) : 1;

    logic [DATA_WIDTH-1:0] w_wr_data [DFI_NUM_PHASES];
    logic [c_MW-1:0]       w_wr_mask [DFI_NUM_PHASES];
    dfi_phase_vec_t        w_wr_en;
    dfi_phase_vec_t        w_rd_en;

    assign w_wr_data[0] = dfi_wrdata_0_p0;
    assign w_wr_data[1] = dfi_wrdata_0_p1;
    assign w_wr_data[2] = dfi_wrdata_1_p2;
    assign w_wr_data[3] = dfi_wrdata_1_p3;
    assign w_wr_mask[0] = dfi_wrdata_mask_0_p0;
    assign w_wr_mask[1] = dfi_wrdata_mask_0_p1;
    assign w_wr_mask[2] = dfi_wrdata_mask_1_p2;
    assign w_wr_mask[3] = dfi_wrdata_mask_1_p3;
    assign w_wr_en = {dfi_wrdata_en_1_p3, dfi_wrdata_en_1_p2, dfi_wrdata_en_0_p1, dfi_wrdata_en_0_p0};
    assign w_rd_en = {dfi_rddata_en_1_p3, dfi_rddata_en_1_p2, dfi_rddata_en_0_p1, dfi_rddata_en_0_p0};

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]       r_rd_ptr;
    logic [c_AW-1:0]       r_wr_ptr;
    logic [c_AW:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;
    logic [c_LAT_W-1:0]    r_lat_q;

    logic [c_AW:0]                             w_n_pop;
    logic [c_AW:0]                             w_n_push;
    logic [c_AW:0]                             w_free;
    logic                                      w_ovf_evt;
    logic                                      w_udf_evt;
    dfi_phase_vec_t                            w_push_ok;
    logic [c_AW-1:0]                           w_push_addr [DFI_NUM_PHASES];
    logic [DATA_WIDTH-1:0]                     w_push_data [DFI_NUM_PHASES];
    logic [DFI_NUM_PHASES-1:0][DATA_WIDTH-1:0] w_pop_data;
    logic [c_LAT_W-1:0]                        w_lat_sat;
    dfi_phase_vec_t                            w_ret_valid;
    logic [DFI_NUM_PHASES-1:0][DATA_WIDTH-1:0] w_ret_data;
    logic                                      w_pipe_busy;

    // Pops read the start-of-cycle contents; pushes then use the space the pops freed.
    always_comb begin
        w_n_pop    = '0;
        w_n_push   = '0;
        w_ovf_evt  = 1'b0;
        w_udf_evt  = 1'b0;
        w_push_ok  = '0;
        w_pop_data = '0;
        for (int p = 0; p < DFI_NUM_PHASES; p++) begin
            w_push_addr[p] = '0;
            w_push_data[p] = DATA_WIDTH'(apply_byte_mask(DFI_MAX_DATA_WIDTH'(w_wr_data[p]),
                                                         DFI_MAX_MASK_WIDTH'(w_wr_mask[p]),
                                                         MASK_FILL));
        end
        for (int p = 0; p < DFI_NUM_PHASES; p++) begin
            if (w_rd_en[p]) begin
                if (w_n_pop < r_count) begin
                    w_pop_data[p] = r_mem[r_rd_ptr + w_n_pop[c_AW-1:0]];
                    w_n_pop       = w_n_pop + (c_AW+1)'(1);
                end else begin
                    w_udf_evt = 1'b1;
                end
            end
        end
        w_free = (c_AW+1)'(DEPTH) - (r_count - w_n_pop);
        for (int p = 0; p < DFI_NUM_PHASES; p++) begin
            if (w_wr_en[p]) begin
                if (w_n_push < w_free) begin
                    w_push_ok[p]   = 1'b1;
                    w_push_addr[p] = r_wr_ptr + w_n_push[c_AW-1:0];
                    w_n_push       = w_n_push + (c_AW+1)'(1);
                end else begin
                    w_ovf_evt = 1'b1;
                end
            end
        end
    end

    assign w_lat_sat = (int'(cfg_rd_lat) > RD_LAT_MAX) ? c_LAT_W'(RD_LAT_MAX) : c_LAT_W'(cfg_rd_lat);

    always_ff @(posedge clk) begin
        for (int p = 0; p < DFI_NUM_PHASES; p++) begin
            if (w_push_ok[p]) begin
                r_mem[w_push_addr[p]] <= w_push_data[p];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr    <= '0;
            r_wr_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_lat_q     <= '0;
        end else begin
            r_rd_ptr    <= r_rd_ptr + w_n_pop[c_AW-1:0];
            r_wr_ptr    <= r_wr_ptr + w_n_push[c_AW-1:0];
            r_count     <= r_count - w_n_pop + w_n_push;
            r_overflow  <= (r_overflow & ~clr_status) | w_ovf_evt;
            r_underflow <= (r_underflow & ~clr_status) | w_udf_evt;
            // Deferred until nothing is in flight so outstanding reads keep their latency.
            if (!w_pipe_busy && (w_rd_en == '0)) begin
                r_lat_q <= w_lat_sat;
            end
        end
    end

    openddr_dfi_lat_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .RD_LAT_MAX (RD_LAT_MAX),
        .LAT_W      (c_LAT_W)
    ) u_lat_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_lat   (r_lat_q),
        .i_valid (w_rd_en),
        .i_data  (w_pop_data),
        .o_valid (w_ret_valid),
        .o_data  (w_ret_data),
        .o_busy  (w_pipe_busy)
    );

    assign dfi_rddata_0_p0       = w_ret_data[0];
    assign dfi_rddata_0_p1       = w_ret_data[1];
    assign dfi_rddata_1_p2       = w_ret_data[2];
    assign dfi_rddata_1_p3       = w_ret_data[3];
    assign dfi_rddata_valid_0_p0 = w_ret_valid[0];
    assign dfi_rddata_valid_0_p1 = w_ret_valid[1];
    assign dfi_rddata_valid_1_p2 = w_ret_valid[2];
    assign dfi_rddata_valid_1_p3 = w_ret_valid[3];
    assign fifo_count            = r_count;
    assign overflow              = r_overflow;
    assign underflow             = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_openddr_dfi_phy_loopback.sv
`default_nettype none
// ============================================================================
// Module      : tb_openddr_dfi_phy_loopback
// Description : Scoreboard bench for the DFI PHY loopback responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_openddr_dfi_phy_loopback;

    typedef struct {
        int               cyc;
        logic [3:0]       v;
        logic [3:0][63:0] d;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [3:0]       cfg_rd_lat;
    logic [3:0][63:0] wd;
    logic [3:0][7:0]  wm;
    logic [3:0]       we;
    logic [3:0]       re;
    logic [3:0][63:0] rd;
    logic [3:0]       rv;
    logic             clr_status;
    logic [4:0]       fifo_count;
    logic             overflow;
    logic             underflow;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc   = 0;
    exp_t q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    openddr_dfi_phy_loopback dut (
        .clk                   (clk),
        .rst                   (rst),
        .cfg_rd_lat            (cfg_rd_lat),
        .dfi_wrdata_0_p0       (wd[0]),
        .dfi_wrdata_0_p1       (wd[1]),
        .dfi_wrdata_1_p2       (wd[2]),
        .dfi_wrdata_1_p3       (wd[3]),
        .dfi_wrdata_mask_0_p0  (wm[0]),
        .dfi_wrdata_mask_0_p1  (wm[1]),
        .dfi_wrdata_mask_1_p2  (wm[2]),
        .dfi_wrdata_mask_1_p3  (wm[3]),
        .dfi_wrdata_en_0_p0    (we[0]),
        .dfi_wrdata_en_0_p1    (we[1]),
        .dfi_wrdata_en_1_p2    (we[2]),
        .dfi_wrdata_en_1_p3    (we[3]),
        .dfi_rddata_en_0_p0    (re[0]),
        .dfi_rddata_en_0_p1    (re[1]),
        .dfi_rddata_en_1_p2    (re[2]),
        .dfi_rddata_en_1_p3    (re[3]),
        .dfi_rddata_0_p0       (rd[0]),
        .dfi_rddata_0_p1       (rd[1]),
        .dfi_rddata_1_p2       (rd[2]),
        .dfi_rddata_1_p3       (rd[3]),
        .dfi_rddata_valid_0_p0 (rv[0]),
        .dfi_rddata_valid_0_p1 (rv[1]),
        .dfi_rddata_valid_1_p2 (rv[2]),
        .dfi_rddata_valid_1_p3 (rv[3]),
        .clr_status            (clr_status),
        .fifo_count            (fifo_count),
        .overflow              (overflow),
        .underflow             (underflow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we         = '0;
        re         = '0;
        wd         = '0;
        wm         = '0;
        clr_status = 1'b0;
    endtask

    // Called while the request is being driven; the return is due 1+lat cycles later.
    task automatic expect_rd(input logic [3:0] v, input logic [63:0] d0, input logic [63:0] d1,
                             input logic [63:0] d2, input logic [63:0] d3, input int lat);
        exp_t e;
        e.cyc = cyc + 1 + lat;
        e.v   = v;
        e.d   = {d3, d2, d1, d0};
        q.push_back(e);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        n_vec++;
        if (rv != 4'b0000) begin
            if (q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_return: cycle %0d valid %b data %h", cyc, rv, rd);
            end else begin
                e = q.pop_front();
                if (cyc != e.cyc || rv !== e.v || rd !== e.d) begin
                    n_err++;
                    $display("FAIL read_return: cycle %0d valid %b data %h, expected cycle %0d valid %b data %h",
                             cyc, rv, rd, e.cyc, e.v, e.d);
                end
            end
        end else if (rd !== '0) begin
            n_err++;
            $display("FAIL idle_data: cycle %0d data %h, expected 0", cyc, rd);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        cfg_rd_lat = 4'd3;
        idle();
        repeat (3) tick();
        chk("reset_count", 64'(fifo_count), 64'd0);
        chk("reset_overflow", 64'(overflow), 64'd0);
        chk("reset_underflow", 64'(underflow), 64'd0);
        chk("reset_valid", 64'(rv), 64'd0);
        rst = 1'b0;
        tick();

        // Four-phase burst, read back two cycles later at latency 3
        we = 4'hF;
        wd = {64'h4444444444444444, 64'h3333333333333333, 64'h2222222222222222, 64'h1111111111111111};
        tick();
        idle();
        tick();
        chk("burst_count_full", 64'(fifo_count), 64'd4);
        re = 4'hF;
        expect_rd(4'hF, 64'h1111111111111111, 64'h2222222222222222,
                  64'h3333333333333333, 64'h4444444444444444, 3);
        tick();
        idle();
        chk("burst_count_empty", 64'(fifo_count), 64'd0);
        repeat (8) tick();

        // Masked single-phase write, returned on a different lane
        we    = 4'b0010;
        wd[1] = 64'hAABBCCDDEEFF0011;
        wm[1] = 8'b0000_0101;
        tick();
        idle();
        chk("mask_count", 64'(fifo_count), 64'd1);
        re = 4'b0100;
        expect_rd(4'b0100, 64'd0, 64'd0, 64'hAABBCCDDEE000000, 64'd0, 3);
        tick();
        idle();
        chk("mask_count_empty", 64'(fifo_count), 64'd0);
        repeat (8) tick();

        // Fill to 16, then push 4 while popping 2
        for (int c = 0; c < 4; c++) begin
            we = 4'hF;
            for (int p = 0; p < 4; p++) wd[p] = 64'h100 + 64'(4 * c + p);
            tick();
        end
        idle();
        chk("fill_count", 64'(fifo_count), 64'd16);
        chk("fill_overflow", 64'(overflow), 64'd0);
        we = 4'hF;
        wd = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
        re = 4'b0011;
        expect_rd(4'b0011, 64'h100, 64'h101, 64'd0, 64'd0, 3);
        tick();
        idle();
        chk("ovf_count", 64'(fifo_count), 64'd16);
        chk("ovf_flag", 64'(overflow), 64'd1);
        re = 4'hF; expect_rd(4'hF, 64'h102, 64'h103, 64'h104, 64'h105, 3); tick();
        re = 4'hF; expect_rd(4'hF, 64'h106, 64'h107, 64'h108, 64'h109, 3); tick();
        re = 4'hF; expect_rd(4'hF, 64'h10A, 64'h10B, 64'h10C, 64'h10D, 3); tick();
        re = 4'hF; expect_rd(4'hF, 64'h10E, 64'h10F, 64'hA0, 64'hA1, 3); tick();
        idle();
        chk("drain_count", 64'(fifo_count), 64'd0);
        chk("drain_overflow_held", 64'(overflow), 64'd1);
        clr_status = 1'b1;
        tick();
        idle();
        chk("ovf_cleared", 64'(overflow), 64'd0);
        repeat (8) tick();

        // Empty reads; clear coinciding with a new underflow keeps the flag
        re = 4'b1001;
        expect_rd(4'b1001, 64'd0, 64'd0, 64'd0, 64'd0, 3);
        tick();
        idle();
        chk("udf_flag", 64'(underflow), 64'd1);
        chk("udf_count", 64'(fifo_count), 64'd0);
        clr_status = 1'b1;
        re         = 4'b0010;
        expect_rd(4'b0010, 64'd0, 64'd0, 64'd0, 64'd0, 3);
        tick();
        idle();
        chk("udf_event_wins", 64'(underflow), 64'd1);
        clr_status = 1'b1;
        tick();
        idle();
        chk("udf_cleared", 64'(underflow), 64'd0);
        repeat (8) tick();

        // Latency change while a read is in flight
        cfg_rd_lat = 4'd2;
        repeat (2) tick();
        we    = 4'b0001;
        wd[0] = 64'h55;
        tick();
        idle();
        re = 4'b0001;
        expect_rd(4'b0001, 64'h55, 64'd0, 64'd0, 64'd0, 2);
        tick();
        idle();
        cfg_rd_lat = 4'd7;
        repeat (10) tick();
        we    = 4'b1000;
        wd[3] = 64'h77;
        tick();
        idle();
        re = 4'b1000;
        expect_rd(4'b1000, 64'd0, 64'd0, 64'd0, 64'h77, 7);
        tick();
        idle();
        repeat (12) tick();

        // Reset between a read request and its return
        we = 4'b0011;
        wd = {64'd0, 64'd0, 64'h92, 64'h91};
        tick();
        idle();
        re = 4'b0001;
        tick();
        idle();
        chk("pre_rst_count", 64'(fifo_count), 64'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_rst_count", 64'(fifo_count), 64'd0);
        chk("post_rst_overflow", 64'(overflow), 64'd0);
        chk("post_rst_underflow", 64'(underflow), 64'd0);
        chk("post_rst_valid", 64'(rv), 64'd0);
        chk("post_rst_data_p0", rd[0], 64'd0);
        repeat (12) tick();

        chk("pending_returns", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
